counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised bank of `CHANNELS` independent `WIDTH`-bit counters sharing one clock and one asynchronous active-high reset. Each channel has its own enable, direction, synchronous clear and parallel load, and a registered terminal-count pulse. A snapshot port captures all channels atomically and presents them on a valid/ready handshake. The block is the general counter primitive for the design: it replaces per-signal ad-hoc counters and their individual reset handling.

## Interface
Parameters:
- `WIDTH`, 8: bits per counter (≥1).
- `CHANNELS`, 4: number of counters (≥1).
- `RESET_VALUE`, 0: value loaded into every counter on reset, truncated to `WIDTH` bits.
- `SATURATE`, 0: 0 = wrap at limits, 1 = hold at limits.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `en`  in  CHANNELS  per-channel count enable.
- `dir`  in  CHANNELS  per-channel direction: 1 = up, 0 = down.
- `clr`  in  CHANNELS  per-channel synchronous clear to 0.
- `load`  in  CHANNELS  per-channel synchronous load.
- `load_data`  in  CHANNELS*WIDTH  load values; channel i at bits [i*WIDTH +: WIDTH].
- `count`  out  CHANNELS*WIDTH  current counter values, same packing.
- `tc`  out  CHANNELS  registered terminal-count pulse.
- `snap_req`  in  1  snapshot request, sampled each cycle.
- `snap_data`  out  CHANNELS*WIDTH  captured counter values.
- `snap_valid`  out  1  snapshot held and presented.
- `snap_ready`  in  1  consumer accepts snapshot.
- `snap_ovf`  out  1  sticky: a request was dropped.
- `snap_ovf_clr`  in  1  synchronous clear of `snap_ovf`.

## Operation
- Reset (RST high, immediate, independent of CLK): every counter = RESET_VALUE; `tc` = 0; `snap_data` = 0; `snap_valid` = 0; `snap_ovf` = 0. Held while RST high; normal operation on first rising edge after deassertion.
- Per-channel priority each edge: `clr` > `load` > `en` > hold.
- Count step (en=1, no clr/load): up adds 1, down subtracts 1, modulo 2^WIDTH.
- Limit: MAX = 2^WIDTH−1 up, 0 down. Step taken at limit: SATURATE=0 wraps (MAX→0 / 0→MAX); SATURATE=1 holds value.
- `tc[i]` = 1 in the cycle after an edge where channel i took (or, saturating, attempted) a step at its limit; else 0. Clear and load never assert `tc`. Continuous enable at a saturated limit gives `tc` high every cycle.
- `dir` is only sampled when a step occurs; changing it mid-count has no other effect.
- Snapshot: slot free when `snap_valid`=0, or `snap_valid`=1 and `snap_ready`=1 in the same cycle. On edge with `snap_req`=1 and slot free: `snap_data` ← all `count` values as they stood before that edge (pre-update), `snap_valid` ← 1. Same edge with `snap_ready`=1 and `snap_req`=0 while valid: `snap_valid` ← 0, `snap_data` held.
- `snap_req`=1 while slot not free: request dropped, `snap_ovf` ← 1, `snap_data`/`snap_valid` unchanged.
- `snap_ovf_clr` clears `snap_ovf`; if a drop occurs the same edge, set wins.
- `snap_data` stable while `snap_valid`=1 and `snap_ready`=0.

## Timing
- All outputs registered; no combinational input→output paths.
- clr/load/en visible on `count` one cycle after the sampling edge.
- `tc` latency: same edge as the wrapped/held `count` update.
- Snapshot latency: `snap_valid` rises one cycle after `snap_req`; back-to-back snapshots (one per cycle) sustained when `snap_ready` held high.
- RST asserted mid-snapshot or mid-count discards all state immediately; pending snapshot lost, `snap_ovf` cleared.

## Test plan
- RESET_VALUE=5, WIDTH=8: assert RST asynchronously between edges → `count` all 0x05, `tc`/`snap_valid`/`snap_ovf` 0 without a clock edge.
- Ch0 up from 0xFE, SATURATE=0, en high 3 cycles → count 0xFF, 0x00, 0x01; `tc[0]` high only the cycle count shows 0x00.
- SATURATE=1, ch1 down from 0x01, en high 3 cycles → 0x00, 0x00, 0x00; `tc[1]` high on 2nd and 3rd cycles only.
- Ch2 clr=1, load=1 (0x3C), en=1 same edge → count 0x00, `tc[2]`=0; next edge load only → 0x3C.
- Ch0=0x10 counting up, `snap_req` pulse → `snap_valid` next cycle with ch0 field 0x10 while `count` shows 0x11; hold `snap_ready`=0 and pulse `snap_req` → `snap_ovf`=1, `snap_data` unchanged; `snap_ready`=1 with `snap_req`=1 same cycle → new capture accepted, `snap_valid` stays 1.
- `snap_ovf_clr` and a dropped request on the same edge → `snap_ovf` remains 1; clr alone next edge → 0.

Source files
------------

// File: rtl/counter_bank.sv
// counter_bank: bank of independent up/down counters with
// terminal-count pulses and an atomic snapshot handshake.
module counter_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_data,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  input  logic                      snap_req,
  output logic [CHANNELS*WIDTH-1:0] snap_data,
  output logic                      snap_valid,
  input  logic                      snap_ready,
  output logic                      snap_ovf,
  input  logic                      snap_ovf_clr
);

  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] tc_d;
  logic [CHANNELS-1:0] at_lim;
  logic                slot_free;

  // Next counter value per channel: clr > load > en > hold
  always_comb begin
    tc_d   = '0;
    at_lim = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      at_lim[i] = dir[i] ? (cnt_q[i] == MAX)
                         : (cnt_q[i] == '0);
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (load[i]) begin
        cnt_d[i] = load_data[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        tc_d[i] = at_lim[i];
        if (!(at_lim[i] && SATURATE != 0))
          cnt_d[i] = dir[i] ? cnt_q[i] + 1'b1
                            : cnt_q[i] - 1'b1;
      end
    end
  end

  // Counter and terminal-count registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++)
        cnt_q[i] <= RV;
      tc <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        cnt_q[i] <= cnt_d[i];
      tc <= tc_d;
    end
  end

  // Pack the counters onto the flat output bus
  always_comb begin
    count = '0;
    for (int i = 0; i < CHANNELS; i++)
      count[i*WIDTH +: WIDTH] = cnt_q[i];
  end

  // Slot frees up when the held snapshot is consumed this cycle
  always_comb slot_free = !snap_valid || snap_ready;

  // Snapshot capture / handshake; captures pre-update counts
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_data  <= '0;
      snap_valid <= 1'b0;
    end else if (snap_req && slot_free) begin
      snap_data  <= count;
      snap_valid <= 1'b1;
    end else if (snap_valid && snap_ready) begin
      snap_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a drop beats a clear on the same edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      snap_ovf <= 1'b0;
    else if (snap_req && !slot_free)
      snap_ovf <= 1'b1;
    else if (snap_ovf_clr)
      snap_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: wrapping and saturating banks driven with
// identical stimulus, checked against a behavioural model.
module tb_counter_bank;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int RV = 5;

  logic         CLK = 1'b0;
  logic         RST;
  logic [C-1:0] en, dir, clr, load;
  logic [31:0]  load_data;
  logic         snap_req, snap_ready, snap_ovf_clr;

  logic [31:0]  cnt_o [2];
  logic [C-1:0] tc_o  [2];
  logic [31:0]  sd_o  [2];
  logic         sv_o  [2];
  logic         ovf_o [2];

  int passed = 0;
  int total  = 0;

  int m_cnt [2][C];
  int m_tc  [2][C];
  int m_sd  [2][C];
  int m_sv  [2];
  int m_ovf [2];

  always #5 CLK = ~CLK;

  counter_bank #(.WIDTH(W), .CHANNELS(C),
    .RESET_VALUE(RV), .SATURATE(0)) u_wrap (
    .CLK(CLK), .RST(RST), .en(en), .dir(dir),
    .clr(clr), .load(load), .load_data(load_data),
    .count(cnt_o[0]), .tc(tc_o[0]),
    .snap_req(snap_req), .snap_data(sd_o[0]),
    .snap_valid(sv_o[0]), .snap_ready(snap_ready),
    .snap_ovf(ovf_o[0]), .snap_ovf_clr(snap_ovf_clr));

  counter_bank #(.WIDTH(W), .CHANNELS(C),
    .RESET_VALUE(RV), .SATURATE(1)) u_sat (
    .CLK(CLK), .RST(RST), .en(en), .dir(dir),
    .clr(clr), .load(load), .load_data(load_data),
    .count(cnt_o[1]), .tc(tc_o[1]),
    .snap_req(snap_req), .snap_data(sd_o[1]),
    .snap_valid(sv_o[1]), .snap_ready(snap_ready),
    .snap_ovf(ovf_o[1]), .snap_ovf_clr(snap_ovf_clr));

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < C; c++) begin
        m_cnt[d][c] = RV;
        m_tc[d][c]  = 0;
        m_sd[d][c]  = 0;
      end
      m_sv[d]  = 0;
      m_ovf[d] = 0;
    end
  endtask

  // One clock edge of the behavioural model, d=1 saturates
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit free;
      free = (m_sv[d] == 0) || snap_ready;
      if (snap_req && !free) m_ovf[d] = 1;
      else if (snap_ovf_clr) m_ovf[d] = 0;
      if (snap_req && free) begin
        for (int c = 0; c < C; c++) m_sd[d][c] = m_cnt[d][c];
        m_sv[d] = 1;
      end else if (m_sv[d] != 0 && snap_ready) begin
        m_sv[d] = 0;
      end
      for (int c = 0; c < C; c++) begin
        int v;
        bit lim;
        v = m_cnt[d][c];
        m_tc[d][c] = 0;
        if (clr[c]) begin
          m_cnt[d][c] = 0;
        end else if (load[c]) begin
          m_cnt[d][c] = int'(load_data[c*W +: W]);
        end else if (en[c]) begin
          lim = dir[c] ? (v == 255) : (v == 0);
          m_tc[d][c] = lim ? 1 : 0;
          if (!(lim && d == 1))
            m_cnt[d][c] = dir[c] ? (v + 1) % 256
                                 : (v + 255) % 256;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int d = 0; d < 2; d++) begin
      logic [31:0]  ec, es;
      logic [C-1:0] et;
      for (int c = 0; c < C; c++) begin
        ec[c*W +: W] = W'(m_cnt[d][c]);
        es[c*W +: W] = W'(m_sd[d][c]);
        et[c]        = m_tc[d][c] != 0;
      end
      chk($sformatf("%s.d%0d.count", tag, d), cnt_o[d], ec);
      chk($sformatf("%s.d%0d.tc", tag, d),
          32'(tc_o[d]), 32'(et));
      chk($sformatf("%s.d%0d.snap_valid", tag, d),
          32'(sv_o[d]), 32'(m_sv[d] != 0));
      chk($sformatf("%s.d%0d.snap_data", tag, d),
          sd_o[d], es);
      chk($sformatf("%s.d%0d.snap_ovf", tag, d),
          32'(ovf_o[d]), 32'(m_ovf[d] != 0));
    end
  endtask

  task automatic cycle(string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic idle();
    en = '0; dir = '0; clr = '0; load = '0;
    load_data = '0; snap_req = 0;
    snap_ready = 0; snap_ovf_clr = 0;
  endtask

  task automatic mid_reset(string tag);
    #2 RST = 1'b1;
    #1 model_reset();
    check_all({tag, ".async"});
    @(negedge CLK);
    RST = 1'b0;
    check_all({tag, ".held"});
  endtask

  initial begin
    RST = 1'b1;
    idle();
    #1 model_reset();
    check_all("por");
    @(negedge CLK);
    RST = 1'b0;

    // Disturb state, then reset between edges
    en = '1; dir = 4'b0101; snap_req = 1;
    cycle("pre1");
    cycle("pre2");
    idle();
    mid_reset("rst");

    // Ch0 up through the wrap point
    load = 4'b0001; load_data = 32'h0000_00FE;
    cycle("ld_fe");
    idle();
    en = 4'b0001; dir = 4'b0001;
    for (int k = 0; k < 3; k++) cycle("up_wrap");
    chk("wrap.ch0_final", 32'(cnt_o[0][7:0]), 32'h01);
    chk("sat.ch0_final", 32'(cnt_o[1][7:0]), 32'hFF);

    // Ch1 down through zero
    idle();
    load = 4'b0010; load_data = 32'h0000_0100;
    cycle("ld_01");
    idle();
    en = 4'b0010; dir = 4'b0000;
    for (int k = 0; k < 3; k++) cycle("dn_lim");
    chk("sat.ch1_tc", 32'(tc_o[1][1]), 32'h1);

    // Ch2 clr beats load and enable
    idle();
    clr = 4'b0100; load = 4'b0100; en = 4'b0100;
    dir = 4'b0100; load_data = 32'h003C_0000;
    cycle("clr_pri");
    clr = '0; en = '0;
    cycle("ld_only");
    chk("ch2_loaded", 32'(cnt_o[0][23:16]), 32'h3C);

    // Snapshot of a running counter
    idle();
    load = 4'b0001; load_data = 32'h10;
    cycle("ld_10");
    idle();
    en = 4'b0001; dir = 4'b0001; snap_req = 1;
    cycle("snap1");
    chk("snap1.ch0", 32'(sd_o[0][7:0]), 32'h10);
    snap_req = 0;
    cycle("snap_hold");
    snap_req = 1;
    cycle("snap_drop");
    snap_req = 0;
    cycle("snap_hold2");
    snap_req = 1; snap_ready = 1;
    cycle("snap_b2b");
    cycle("snap_b2b2");

    // Drop and clear on the same edge, then clear alone
    snap_ready = 0; snap_req = 1; snap_ovf_clr = 1;
    cycle("ovf_set_wins");
    snap_req = 0;
    cycle("ovf_clr");
    snap_ovf_clr = 0; snap_ready = 1;
    cycle("drain");

    // Randomised traffic with a reset in the middle
    for (int k = 0; k < 600; k++) begin
      en  = C'($urandom);
      dir = C'($urandom);
      clr = '0; load = '0;
      for (int c = 0; c < C; c++) begin
        clr[c]  = ($urandom_range(0, 15) == 0);
        load[c] = ($urandom_range(0, 9) == 0);
      end
      load_data    = $urandom;
      if ($urandom_range(0, 3) == 0)
        for (int c = 0; c < C; c++)
          load_data[c*W +: W] =
            ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      snap_req     = $urandom_range(0, 1) != 0;
      snap_ready   = $urandom_range(0, 2) != 0;
      snap_ovf_clr = $urandom_range(0, 7) == 0;
      cycle("rnd");
      if (k == 300) mid_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
